// File: rtl/ippcsge_link_sup.sv
// ippcsge_link_sup: debounces PCS sync/xmit/rudi into a qualified link_up and restarts autoneg on timeout
module ippcsge_link_sup #(
  parameter logic [15:0] UP_DLY = 16'd1000,
  parameter logic [15:0] DN_DLY = 16'd8,
  parameter logic [19:0] RESTART_TO = 20'd600000,
  parameter logic [3:0] RESTART_PW = 4'd4,
  parameter int CNT_W = 16
) (
  input  logic             rxclk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [1:0]       xmit,
  input  logic [1:0]       rudi,
  input  logic             clr_cnt,
  output logic             an_restart,
  output logic             link_up,
  output logic             link_chg,
  output logic [2:0]       link_state,
  output logic [CNT_W-1:0] flap_cnt,
  output logic [CNT_W-1:0] restart_cnt
);
  typedef enum logic [2:0] {
    DOWN = 3'd0, WAIT_AN = 3'd1, QUALIFY = 3'd2, UP = 3'd3, HOLD = 3'd4, RESTART = 3'd5
  } state_t;
  localparam logic [19:0] UP_LAST = 20'(UP_DLY - 16'd1);
  localparam logic [19:0] DN_LAST = 20'(DN_DLY - 16'd2);
  localparam logic [19:0] TO_LAST = RESTART_TO - 20'd1;
  localparam logic [19:0] PW_LAST = 20'(RESTART_PW - 4'd1);
  state_t state_q, state_d;
  logic [19:0] timer_q, timer_d;
  logic an_restart_q, an_restart_d, link_up_q, link_up_d, link_chg_q, link_chg_d;
  logic [CNT_W-1:0] flap_cnt_q, flap_cnt_d, restart_cnt_q, restart_cnt_d;
  logic good, flap_inc, restart_inc;
  assign good = sync & (xmit == 2'd2) & (rudi != 2'b11);
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    flap_inc = 1'b0;
    if (!en) state_d = DOWN;
    else case (state_q)
      DOWN: state_d = WAIT_AN;
      WAIT_AN: if (good) state_d = QUALIFY;
               else if (timer_q == TO_LAST) state_d = RESTART;
               else timer_d = timer_q + 20'd1;
      RESTART: if (timer_q == PW_LAST) state_d = WAIT_AN;
               else timer_d = timer_q + 20'd1;
      QUALIFY: if (!good) state_d = WAIT_AN;
               else if (timer_q == UP_LAST) state_d = UP;
               else timer_d = timer_q + 20'd1;
      UP: if (!good) begin
            state_d = (DN_DLY == 16'd1) ? WAIT_AN : HOLD;
            flap_inc = (DN_DLY == 16'd1);
          end
      HOLD: if (good) state_d = UP;
            else if (timer_q == DN_LAST || DN_DLY == 16'd1) begin
              state_d = WAIT_AN;
              flap_inc = 1'b1;
            end else timer_d = timer_q + 20'd1;
      default: state_d = DOWN;
    endcase
    restart_inc = (state_d == RESTART) && (state_q != RESTART);
    an_restart_d = state_d == RESTART;
    link_up_d = (state_d == UP) || (state_d == HOLD);
    link_chg_d = link_up_d ^ link_up_q;
    flap_cnt_d = clr_cnt ? CNT_W'(flap_inc) : flap_cnt_q + CNT_W'(flap_inc & ~&flap_cnt_q);
    restart_cnt_d = clr_cnt ? CNT_W'(restart_inc) : restart_cnt_q + CNT_W'(restart_inc & ~&restart_cnt_q);
  end
  always_ff @(posedge rxclk or posedge rst) begin
    if (rst) begin
      state_q <= DOWN;
      timer_q <= '0;
      an_restart_q <= 1'b0;
      link_up_q <= 1'b0;
      link_chg_q <= 1'b0;
      flap_cnt_q <= '0;
      restart_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      an_restart_q <= an_restart_d;
      link_up_q <= link_up_d;
      link_chg_q <= link_chg_d;
      flap_cnt_q <= flap_cnt_d;
      restart_cnt_q <= restart_cnt_d;
    end
  end
  assign an_restart = an_restart_q;
  assign link_up = link_up_q;
  assign link_chg = link_chg_q;
  assign link_state = state_q;
  assign flap_cnt = flap_cnt_q;
  assign restart_cnt = restart_cnt_q;
endmodule

// File: tb/tb_ippcsge_link_sup.sv
// tb_ippcsge_link_sup: scoreboard bench for the link supervisor with small timing parameters
module tb_ippcsge_link_sup;
  logic rxclk = 1'b0, rst = 1'b1, en = 1'b0, sync = 1'b0, clr_cnt = 1'b0;
  logic [1:0] xmit = 2'd0, rudi = 2'd0;
  logic an_restart, link_up, link_chg;
  logic [2:0] link_state;
  logic [3:0] flap_cnt, restart_cnt;
  logic [13:0] obs;
  logic [13:0] exp_q[$];
  int checks = 0, failures = 0;
  always #5 rxclk = ~rxclk;
  ippcsge_link_sup #(.UP_DLY(16'd4), .DN_DLY(16'd3), .RESTART_TO(20'd10), .RESTART_PW(4'd2), .CNT_W(4)) dut (
    .rxclk(rxclk), .rst(rst), .en(en), .sync(sync), .xmit(xmit), .rudi(rudi), .clr_cnt(clr_cnt),
    .an_restart(an_restart), .link_up(link_up), .link_chg(link_chg), .link_state(link_state),
    .flap_cnt(flap_cnt), .restart_cnt(restart_cnt)
  );
  assign obs = {link_state, link_up, link_chg, an_restart, flap_cnt, restart_cnt};
  function automatic logic [13:0] mk(input logic [2:0] st, input logic lu, input logic lc, input logic ar,
                                     input logic [3:0] fc, input logic [3:0] rc);
    return {st, lu, lc, ar, fc, rc};
  endfunction
  task automatic drive(input int kind);
    sync = kind != 1;
    xmit = (kind == 2) ? 2'd1 : 2'd2;
    rudi = (kind == 3) ? 2'b11 : 2'b10;
  endtask
  task automatic step;
    @(posedge rxclk);
    #1;
  endtask
  task automatic test_reset;
    logic [13:0] e;
    en = 1'b1;
    drive(0);
    step;
    step;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0));
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", obs, e);
    end
    en = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_link_up;
    logic [13:0] e;
    en = 1'b1;
    drive(0);
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(k == 1 ? mk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0) :
                      k < 6  ? mk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0) :
                      k == 6 ? mk(3'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0) :
                               mk(3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL link_up edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask
  task automatic test_hold_recover;
    logic [13:0] e;
    int kinds[4] = '{1, 3, 0, 0};
    logic [2:0] sts[4] = '{3'd4, 3'd4, 3'd3, 3'd3};
    for (int k = 0; k < 4; k++) begin
      drive(kinds[k]);
      exp_q.push_back(mk(sts[k], 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL hold_recover edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask
  task automatic test_flap;
    logic [13:0] e;
    int kinds[3] = '{2, 1, 3};
    for (int k = 0; k < 3; k++) begin
      drive(kinds[k]);
      exp_q.push_back(k < 2 ? mk(3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0) : mk(3'd1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL flap edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask
  task automatic test_saturate;
    logic [13:0] e;
    logic [3:0] fc = 4'd1;
    logic [2:0] st;
    for (int f = 0; f < 18; f++) begin
      for (int i = 0; i < 8; i++) begin
        clr_cnt = (f == 0 && i == 0) || (f == 17 && i == 7);
        drive(i < 5 ? 0 : i - 4);
        if (f == 0 && i == 0) fc = 4'd0;
        if (i == 7) fc = (f == 17) ? 4'd1 : (fc == 4'hF) ? 4'hF : fc + 4'd1;
        st = i < 4 ? 3'd2 : i == 4 ? 3'd3 : i < 7 ? 3'd4 : 3'd1;
        exp_q.push_back(mk(st, i >= 4 && i < 7, i == 4 || i == 7, 1'b0, fc, 4'd0));
        step;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL saturate flap=%0d edge=%0d got=%b exp=%b", f, i, obs, e);
        end
      end
    end
    clr_cnt = 1'b0;
  endtask
  task automatic test_restart;
    logic [13:0] e;
    logic [3:0] rc = 4'd0;
    logic ar;
    drive(1);
    for (int k = 1; k <= 24; k++) begin
      if ((k - 1) % 12 == 9) rc = rc + 4'd1;
      ar = ((k - 1) % 12 == 9) || ((k - 1) % 12 == 10);
      exp_q.push_back(mk(ar ? 3'd5 : 3'd1, 1'b0, 1'b0, ar, 4'd1, rc));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL restart edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask
  task automatic test_en_drop;
    logic [13:0] e;
    drive(0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) en = 1'b0;
      if (k == 8) begin
        en = 1'b1;
        drive(1);
      end
      exp_q.push_back(k < 5  ? mk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2) :
                      k == 5 ? mk(3'd3, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2) :
                      k == 6 ? mk(3'd0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2) :
                      k == 7 ? mk(3'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2) :
                               mk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL en_drop edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
  endtask
  task automatic test_reset_in_restart;
    logic [13:0] e;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(k < 10 ? mk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2) : mk(3'd5, 1'b0, 1'b0, 1'b1, 4'd1, 4'd3));
      step;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_in_restart edge=%0d got=%b exp=%b", k, obs, e);
      end
    end
    rst = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", obs, e);
    end
    step;
    rst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_link_up;
    test_hold_recover;
    test_flap;
    test_saturate;
    test_restart;
    test_en_drop;
    test_reset_in_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
